// File: rtl/bch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bch_pkg
// Description : Shared constants, state type and LFSR step function for the
//               BCH(31,16,t=3) encoder and decoder.
//               N        - codeword length (31)
//               K        - message length (16)
//               NK       - parity length (15)
//               GEN_POLY - generator polynomial g(x) = 0x8FAF
// Revision    : 1.0 - initial release
// ============================================================================
package bch_pkg;

    localparam int          N        = 31;
    localparam int          K        = 16;
    localparam int          NK       = N - K;
    localparam logic [15:0] GEN_POLY = 16'h8FAF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bch_state_t;

    // One step of the division register: the x^15 term of g(x) is implicit,
    // so only the low NK bits of the generator are folded back in.
    function automatic logic [NK-1:0] lfsr_step(input logic [NK-1:0] r,
                                                input logic          b);
        logic fb;
        fb = b ^ r[NK-1];
        return {r[NK-2:0], 1'b0} ^ (fb ? GEN_POLY[NK-1:0] : {NK{1'b0}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : bch_lfsr
// Description : 15-bit polynomial division register for the BCH encoder.
//               Ports:
//                 clk      - system clock, rising edge
//                 reset    - synchronous active-high reset
//                 clear    - synchronous clear (start of a new message)
//                 shift_en - advance one message bit
//                 bit_in   - message bit, MSB first
//                 r        - current remainder
// Revision    : 1.0 - initial release
// ============================================================================
module bch_lfsr
    import bch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          shift_en,
    input  logic          bit_in,
    output logic [NK-1:0] r
);

    logic [NK-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_lfsr <= '0;
        end else if (shift_en) begin
            r_lfsr <= lfsr_step(r_lfsr, bit_in);
        end
    end

    assign r = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/bch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bch_encoder
// Description : Bit-serial systematic BCH(31,16,t=3) encoder.
//               A message is accepted when idle and readready is high, then
//               shifted MSB first through the division register for 16
//               cycles; the codeword {data, parity} is registered on the last
//               shift together with a one-cycle outready pulse.
//               Ports:
//                 clk       - system clock, rising edge
//                 reset     - synchronous active-high reset
//                 data      - message word, sampled on accept
//                 readready - encode request, ignored while busy
//                 busy      - encoding in progress
//                 outready  - one-cycle pulse, outdata holds a new codeword
//                 outdata   - codeword {data, parity}
//                 err_mask  - (BCH_ENC_ERRINJ_EN only) error pattern XORed
//                             into the codeword, sampled on accept
//               Optional build macro: BCH_ENC_ERRINJ_EN
// Revision    : 1.0 - initial release
// ============================================================================
module bch_encoder #(
    parameter int N = bch_pkg::N,
    parameter int K = bch_pkg::K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] data,
    input  logic         readready,
`ifdef BCH_ENC_ERRINJ_EN
    input  logic [N-1:0] err_mask,
`endif
    output logic         busy,
    output logic         outready,
    output logic [N-1:0] outdata
);

    import bch_pkg::*;

    localparam int CNT_W = $clog2(K);

    bch_state_t       r_state;
    bch_state_t       w_state_next;
    logic             w_accept;
    logic             w_last;
    logic             w_shift;
    logic             w_bit;
    logic [K-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [NK-1:0]    w_r;
    logic [N-1:0]     w_mask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_shift      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (readready) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                // Counter holds the index of the bit being shifted, so the
                // final (LSB) shift happens while it reads zero.
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_bit = r_data[r_cnt];

    // ------------------------------------------------------------------
    // Optional error injection
    // ------------------------------------------------------------------
`ifdef BCH_ENC_ERRINJ_EN
    logic [N-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= err_mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Division register
    // ------------------------------------------------------------------
    bch_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_accept),
        .shift_en (w_shift),
        .bit_in   (w_bit),
        .r        (w_r)
    );

    // ------------------------------------------------------------------
    // Message latch, bit counter and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_cnt    <= '0;
            outready <= 1'b0;
            outdata  <= '0;
        end else begin
            outready <= 1'b0;
            if (w_accept) begin
                r_data <= data;
                r_cnt  <= CNT_W'(K - 1);
            end else if (w_shift) begin
                if (w_last) begin
                    // Parity is taken from the remainder including this
                    // final bit, not the value still held in the register.
                    outdata  <= {r_data, lfsr_step(w_r, w_bit)} ^ w_mask;
                    outready <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bch_encoder
// Description : Self-checking testbench for bch_encoder. A behavioural model
//               (polynomial long division and a busy countdown) predicts
//               busy/outready/outdata every cycle; directed cases pin the
//               model with literal codewords.
//               Optional build macro: BCH_ENC_ERRINJ_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        readready;
    logic        busy;
    logic        outready;
    logic [30:0] outdata;
`ifdef BCH_ENC_ERRINJ_EN
    logic [30:0] err_mask = '0;
`endif

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    bch_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .readready (readready),
`ifdef BCH_ENC_ERRINJ_EN
        .err_mask  (err_mask),
`endif
        .busy      (busy),
        .outready  (outready),
        .outdata   (outdata)
    );

    // ------------------------------------------------------------------
    // Reference arithmetic: GF(2) long division by g(x)
    // ------------------------------------------------------------------
    function automatic logic [14:0] poly_rem(input logic [30:0] v);
        logic [30:0] m;
        logic [30:0] g;
        m = v;
        g = 31'h8FAF;
        for (int i = 30; i >= 15; i--) begin
            if (m[i]) m = m ^ (g << (i - 15));
        end
        return m[14:0];
    endfunction

    function automatic logic [30:0] ref_encode(input logic [15:0] d);
        return {d, poly_rem({d, 15'b0})};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: accept when idle, deliver 16 edges later
    // ------------------------------------------------------------------
    int          m_remain  = 0;
    logic        m_outready = 1'b0;
    logic [30:0] m_outdata = '0;
    logic [30:0] m_cw      = '0;
    logic [30:0] m_mask    = '0;
    logic [15:0] m_data    = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_remain   = 0;
            m_outready = 1'b0;
            m_outdata  = '0;
        end else begin
            m_outready = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_outready = 1'b1;
                    m_outdata  = m_cw ^ m_mask;
                end
            end else if (readready) begin
                m_remain = 16;
                m_data   = data;
                m_cw     = ref_encode(data);
`ifdef BCH_ENC_ERRINJ_EN
                m_mask   = err_mask;
`else
                m_mask   = '0;
`endif
            end
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        if (chk_en) begin
            logic [30:0] clean;
            check("busy", {31'b0, busy}, {31'b0, m_remain > 0});
            check("outready", {31'b0, outready}, {31'b0, m_outready});
            check("outdata", {1'b0, outdata}, {1'b0, m_outdata});
            if (outready) begin
                clean = outdata ^ m_mask;
                check("systematic", {16'b0, clean[30:15]}, {16'b0, m_data});
                check("rem_zero", {17'b0, poly_rem(clean)}, 32'h0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic run_one(input logic [15:0] d, input logic [30:0] exp,
                           input bit use_exp);
        int lat;
        bit got;
        @(negedge clk);
        data      = d;
        readready = 1'b1;
        @(negedge clk);
        readready = 1'b0;
        data      = 16'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (outready) got = 1'b1;
        end
        check("latency", 32'(lat), 32'd16);
        if (use_exp) check("cw_literal", {1'b0, outdata}, {1'b0, exp});
    endtask

    initial begin
        int rises;
        int pulses;
        logic prev_busy;

        reset     = 1'b1;
        readready = 1'b0;
        data      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_outready", {31'b0, outready}, 32'h0);
        check("rst_outdata", {1'b0, outdata}, 32'h0);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Pin the reference model
        check("model_0000", {1'b0, ref_encode(16'h0000)}, 32'h0000_0000);
        check("model_0001", {1'b0, ref_encode(16'h0001)}, 32'h0000_8FAF);
        check("model_0002", {1'b0, ref_encode(16'h0002)}, 32'h0001_1F5E);

        // Directed codewords
        run_one(16'h0000, 31'h0000_0000, 1'b1);
        run_one(16'h0001, 31'h0000_8FAF, 1'b1);
        run_one(16'h0002, 31'h0001_1F5E, 1'b1);

        // Random messages
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            run_one(d, ref_encode(d), 1'b1);
        end

        // readready held high for 40 cycles: three accepts, none while busy
        @(negedge clk);
        prev_busy = busy;
        readready = 1'b1;
        data      = 16'hA5C3;
        rises     = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            data = 16'($urandom);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        readready = 1'b0;
        check("hold_accepts", 32'(rises), 32'd3);
        repeat (20) @(negedge clk);

        // Reset in the middle of a message
        @(negedge clk);
        data      = 16'h1234;
        readready = 1'b1;
        @(negedge clk);
        readready = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_outdata", {1'b0, outdata}, 32'h0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (outready) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        run_one(16'h0002, 31'h0001_1F5E, 1'b1);

`ifdef BCH_ENC_ERRINJ_EN
        err_mask = 31'h4000_0001;
        run_one(16'h0001, 31'h4000_8FAE, 1'b1);
        err_mask = '0;
        run_one(16'h0001, 31'h0000_8FAF, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
